// File: rtl/spi_slave_rx_multi.sv
// SPI slave receiver with single/dual/quad lanes, clocked directly by sclk.
// The first word after cs falls is a fixed-length command. Later word lengths are set
// by counter_in/counter_in_upd. Completed words go to a one-deep output register with
// a valid/ready handshake and a sticky overflow flag.
module spi_slave_rx_multi #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 8,
  parameter int unsigned CMD_BITS   = 8
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  cs,
  input  logic [3:0]            sdi,
  input  logic [1:0]            lane_mode,
  input  logic [CNT_WIDTH-1:0]  counter_in,
  input  logic                  counter_in_upd,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overflow,
  input  logic                  overflow_clr,
  output logic                  busy
);

  // Command-word targets: shift cycles minus one for each lane width.
  localparam logic [CNT_WIDTH-1:0] CmdTgtSingle = CNT_WIDTH'(CMD_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] CmdTgtDual   = CNT_WIDTH'(CMD_BITS / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] CmdTgtQuad   = CNT_WIDTH'(CMD_BITS / 4 - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWait
  } state_t;

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  counter_q;
  logic [CNT_WIDTH-1:0]  target_q;
  logic [DATA_WIDTH-1:0] shreg_q;

  logic [DATA_WIDTH-1:0] shreg_shift;
  logic [CNT_WIDTH-1:0]  cmd_target;
  logic                  word_done;

  // Shift-in value and command target, both following the lane mode of this cycle.
  always_comb begin
    shreg_shift = {shreg_q[DATA_WIDTH-2:0], sdi[0]};
    cmd_target  = CmdTgtSingle;
    case (lane_mode)
      2'b01: begin
        shreg_shift = {shreg_q[DATA_WIDTH-3:0], sdi[1:0]};
        cmd_target  = CmdTgtDual;
      end
      2'b10: begin
        shreg_shift = {shreg_q[DATA_WIDTH-5:0], sdi[3:0]};
        cmd_target  = CmdTgtQuad;
      end
      default: begin
        // Single lane; the reserved encoding 2'b11 also lands here.
        shreg_shift = {shreg_q[DATA_WIDTH-2:0], sdi[0]};
        cmd_target  = CmdTgtSingle;
      end
    endcase
  end

  // A word completes on the RUN cycle where the counter reaches the target.
  assign word_done = !cs && (state_q == StRun) && (counter_q == target_q);

  // Frame FSM, shift counter, word target and shift register.
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      counter_q <= '0;
      target_q  <= '0;
      shreg_q   <= '0;
      busy      <= 1'b0;
    end else if (cs) begin
      // Deselect aborts any partial word; the target is left alone.
      state_q   <= StIdle;
      counter_q <= '0;
      shreg_q   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q   <= StRun;
          counter_q <= '0;
          target_q  <= cmd_target;
          busy      <= 1'b1;
        end
        StRun: begin
          shreg_q <= shreg_shift;
          if (counter_q == target_q) begin
            counter_q <= '0;
          end else begin
            counter_q <= counter_q + CNT_WIDTH'(1);
          end
          if (counter_in_upd) begin
            target_q <= counter_in;
          end else if (counter_q == target_q) begin
            state_q <= StWait;
            busy    <= 1'b0;
          end
        end
        StWait: begin
          // Shift register and counter hold; only a new target re-arms reception.
          if (counter_in_upd) begin
            target_q <= counter_in;
            state_q  <= StRun;
            busy     <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          counter_q <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Output word register with valid/ready handshake and sticky overflow (set beats clear).
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      data_o     <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (word_done) begin
        if (!data_valid || data_ready) begin
          data_o     <= shreg_shift;
          data_valid <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (word_done && data_valid && !data_ready) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_multi.sv
// Self-checking bench for spi_slave_rx_multi: a reference model predicts delivered words
// into a scoreboard queue; a negedge monitor compares the DUT against it every cycle.
module tb_spi_slave_rx_multi;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int CMD = 8;

  logic          sclk = 1'b0;
  logic          rstn;
  logic          cs;
  logic [3:0]    sdi;
  logic [1:0]    lane_mode;
  logic [CW-1:0] counter_in;
  logic          counter_in_upd;
  logic [DW-1:0] data_o;
  logic          data_valid;
  logic          data_ready;
  logic          overflow;
  logic          overflow_clr;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Scoreboard of words delivered into data_o and not yet consumed.
  logic [DW-1:0] exp_q[$];

  // Reference model state: 0 idle, 1 receiving, 2 waiting for a new target.
  int            m_st;
  logic [CW-1:0] m_cnt;
  logic [CW-1:0] m_tgt;
  logic [DW-1:0] m_acc;
  bit            m_valid;
  bit            m_ovf;
  bit            mon_en = 1'b0;

  spi_slave_rx_multi #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW),
    .CMD_BITS  (CMD)
  ) dut (
    .sclk          (sclk),
    .rstn          (rstn),
    .cs            (cs),
    .sdi           (sdi),
    .lane_mode     (lane_mode),
    .counter_in    (counter_in),
    .counter_in_upd(counter_in_upd),
    .data_o        (data_o),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .busy          (busy)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lanes_of(input logic [1:0] lm);
    if (lm == 2'b01) return 2;
    if (lm == 2'b10) return 4;
    return 1;
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_step();
    int            l;
    bit            wc;
    bit            ovf_set;
    logic [DW-1:0] ln;
    l       = lanes_of(lane_mode);
    wc      = 1'b0;
    ovf_set = 1'b0;
    if (!rstn) begin
      m_st = 0; m_cnt = '0; m_tgt = '0; m_acc = '0; m_valid = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
      return;
    end
    if (cs) begin
      m_st = 0; m_cnt = '0; m_acc = '0;
    end else if (m_st == 0) begin
      m_st  = 1;
      m_cnt = '0;
      m_tgt = CW'(CMD / l - 1);
    end else if (m_st == 1) begin
      ln    = DW'(sdi) & DW'((1 << l) - 1);
      m_acc = (m_acc << l) | ln;
      if (m_cnt == m_tgt) begin
        wc    = 1'b1;
        m_cnt = '0;
        m_st  = counter_in_upd ? 1 : 2;
      end else begin
        m_cnt = m_cnt + 1'b1;
      end
      if (counter_in_upd) m_tgt = counter_in;
    end else if (counter_in_upd) begin
      m_tgt = counter_in;
      m_st  = 1;
    end
    if (wc) begin
      if (!m_valid || data_ready) begin
        exp_q.push_back(m_acc);
        m_valid = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_valid && data_ready) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (overflow_clr) m_ovf = 1'b0;
  endtask

  // One clock with the inputs as currently driven; the model follows just after the edge.
  task automatic step();
    @(posedge sclk);
    #1;
    model_step();
  endtask

  // Shift n beats of val MSB-first at the given lane mode; optional target update on last beat.
  task automatic send(input logic [1:0] lm, input logic [63:0] val, input int n,
                      input bit upd_last, input logic [CW-1:0] cin);
    int         l;
    logic [3:0] mask;
    logic [63:0] beat;
    l         = lanes_of(lm);
    mask      = 4'((1 << l) - 1);
    lane_mode = lm;
    for (int i = 0; i < n; i++) begin
      beat           = val >> ((n - 1 - i) * l);
      sdi            = beat[3:0] & mask;
      counter_in_upd = upd_last && (i == n - 1);
      counter_in     = cin;
      step();
    end
    counter_in_upd = 1'b0;
  endtask

  // Monitor: compare status every cycle and data_o against the scoreboard head.
  always @(negedge sclk) begin
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(m_st == 1));
      chk("data_valid", 64'(data_valid), 64'(m_valid));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_o: got %0h expected a queued word, none queued", data_o);
        end else begin
          chk("data_o", 64'(data_o), 64'(exp_q[0]));
          if (data_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; cs = 1'b1; sdi = '0; lane_mode = '0; counter_in = '0;
    counter_in_upd = 1'b0; data_ready = 1'b1; overflow_clr = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    chk("reset data_o", 64'(data_o), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);

    // Single lane command word 0xA5.
    rstn = 1'b1; cs = 1'b0; step();
    send(2'b00, 64'hA5, 8, 1'b0, '0);
    chk("single word", 64'(data_o[7:0]), 64'hA5);
    chk("single wait", 64'(busy), 64'h0);
    step();
    chk("single valid 1 cycle", 64'(data_valid), 64'h0);

    // Quad: command 0xC3, then target 7 with no gap, 0xDEADBEEF.
    cs = 1'b1; step();
    cs = 1'b0; lane_mode = 2'b10; step();
    send(2'b10, 64'hC3, 2, 1'b1, CW'(7));
    chk("quad cmd", 64'(data_o[7:0]), 64'hC3);
    chk("quad no wait gap", 64'(busy), 64'h1);
    send(2'b10, 64'hDEADBEEF, 8, 1'b0, '0);
    chk("quad word", 64'(data_o), 64'hDEADBEEF);

    // Dual with consumer stalled: second word dropped, overflow sticky then cleared.
    cs = 1'b1; step();
    cs = 1'b0; lane_mode = 2'b01; data_ready = 1'b0; step();
    send(2'b01, 64'hB4, 4, 1'b0, '0);
    counter_in = CW'(3); counter_in_upd = 1'b1; step();
    counter_in_upd = 1'b0;
    send(2'b01, 64'h5A, 4, 1'b0, '0);
    chk("dual overflow", 64'(overflow), 64'h1);
    chk("dual kept word", 64'(data_o[7:0]), 64'hB4);
    overflow_clr = 1'b1; step();
    overflow_clr = 1'b0;
    chk("dual overflow clr", 64'(overflow), 64'h0);
    data_ready = 1'b1; step();

    // Abort after 5 bits, then a clean 0x3C frame.
    cs = 1'b1; step();
    cs = 1'b0; step();
    send(2'b00, 64'h1F, 5, 1'b0, '0);
    cs = 1'b1; step();
    chk("abort idle", 64'(busy), 64'h0);
    cs = 1'b0; step();
    send(2'b00, 64'h3C, 8, 1'b0, '0);
    chk("after abort", 64'(data_o[7:0]), 64'h3C);

    // Reset mid-word with a pending word.
    data_ready = 1'b0; cs = 1'b1; step();
    cs = 1'b0; step();
    send(2'b00, 64'h81, 8, 1'b0, '0);
    counter_in = CW'(7); counter_in_upd = 1'b1; step();
    counter_in_upd = 1'b0;
    send(2'b00, 64'h3, 3, 1'b0, '0);
    rstn = 1'b0; step();
    chk("rst data_o", 64'(data_o), 64'h0);
    chk("rst valid", 64'(data_valid), 64'h0);
    chk("rst busy", 64'(busy), 64'h0);
    rstn = 1'b1; step();
    data_ready = 1'b1;
    send(2'b00, 64'h66, 8, 1'b0, '0);
    chk("post rst word", 64'(data_o[7:0]), 64'h66);

    // Back-to-back: target 0 completes every cycle while valid and ready are both high.
    data_ready = 1'b0; counter_in = '0; counter_in_upd = 1'b1; step();
    data_ready = 1'b1; sdi = 4'h1; step();
    sdi = 4'h0; step();
    chk("b2b valid", 64'(data_valid), 64'h1);
    chk("b2b overflow", 64'(overflow), 64'h0);
    chk("b2b word", 64'(data_o), 64'h19A);
    counter_in_upd = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rstn           = ($urandom_range(0, 199) != 0);
      cs             = ($urandom_range(0, 39) == 0);
      sdi            = 4'($urandom);
      if ($urandom_range(0, 7) == 0) lane_mode = 2'($urandom);
      counter_in     = CW'($urandom_range(0, 9));
      counter_in_upd = ($urandom_range(0, 5) == 0);
      data_ready     = ($urandom_range(0, 2) != 0);
      overflow_clr   = ($urandom_range(0, 15) == 0);
      step();
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
